// File: rtl/two_power_arbiter_pkg.sv
// Shared types for the TwoPower datapath and its round-robin arbiter.
// MOD_WIDTH sets the result width of the shared TwoPower datapath.
package two_power_arbiter_pkg;

    localparam int unsigned MOD_WIDTH         = 16;
    localparam int unsigned TPA_N_REQ_DEFAULT = 4;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] power;
        logic [MOD_WIDTH-1:0] modulus;
    } TwoPowerIn;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] value;
    } TwoPowerOut;

    typedef enum logic [1:0] {TPA_IDLE, TPA_ISSUE, TPA_WAIT, TPA_RETURN} TwoPowerArbState;

    // Round-robin successor of idx among n ports.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/two_power_arbiter_if.sv
// Requester and datapath handshake bundle for two_power_arbiter.
interface two_power_arbiter_if
    import two_power_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = TPA_N_REQ_DEFAULT
);

    logic      [N_REQ-1:0] req_valid;
    logic      [N_REQ-1:0] req_ready;
    TwoPowerIn [N_REQ-1:0] req_in;
    logic      [N_REQ-1:0] rsp_valid;
    logic      [N_REQ-1:0] rsp_ready;
    TwoPowerOut            rsp_out;
    logic                  dp_i_valid;
    logic                  dp_i_ready;
    TwoPowerIn             dp_i_in;
    logic                  dp_o_valid;
    logic                  dp_o_ready;
    TwoPowerOut            dp_o_out;

    // master: the arbiter; slave: requesters plus datapath.
    modport master (
        input  req_valid, req_in, rsp_ready, dp_i_ready, dp_o_valid, dp_o_out,
        output req_ready, rsp_valid, rsp_out, dp_i_valid, dp_i_in, dp_o_ready
    );

    modport slave (
        output req_valid, req_in, rsp_ready, dp_i_ready, dp_o_valid, dp_o_out,
        input  req_ready, rsp_valid, rsp_out, dp_i_valid, dp_i_in, dp_o_ready
    );

endinterface

// File: rtl/two_power_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_priority_picker #(
    parameter int unsigned N = 4,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] index,
    output logic         any
);

    logic [W-1:0] pos;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = W'((32'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any        = 1'b1;
                grant[pos] = 1'b1;
                index      = pos;
            end
        end
    end

endmodule

// File: rtl/two_power_arbiter.sv
// Round-robin scheduler sharing one TwoPower datapath among N_REQ requesters,
// one job in flight at a time.
module two_power_arbiter
    import two_power_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = TPA_N_REQ_DEFAULT,
    localparam int unsigned OWNER_W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    two_power_arbiter_if.master bus,
    output logic               busy,
    output logic [OWNER_W-1:0] owner,
    output logic               err_stray
);

    TwoPowerArbState    state_q, state_d;
    TwoPowerIn          req_q, req_d;
    TwoPowerOut         rsp_q, rsp_d;
    logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               err_q, err_d;

    logic [N_REQ-1:0]   grant;
    logic [OWNER_W-1:0] grant_idx;
    logic               grant_any;

    rr_priority_picker #(
        .N(N_REQ)
    ) u_picker (
        .req  (bus.req_valid),
        .ptr  (rr_ptr_q),
        .grant(grant),
        .index(grant_idx),
        .any  (grant_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= TPA_IDLE;
            req_q    <= '0;
            rsp_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rsp_q    <= rsp_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        req_d          = req_q;
        rsp_d          = rsp_q;
        rr_ptr_d       = rr_ptr_q;
        owner_d        = owner_q;
        err_d          = err_q;
        bus.req_ready  = '0;
        bus.rsp_valid  = '0;
        bus.dp_i_valid = 1'b0;
        bus.dp_o_ready = 1'b0;

        unique case (state_q)
            TPA_IDLE: begin
                // Gate with rst_n so no grant leaks out while reset is held.
                if (grant_any && rst_n) begin
                    bus.req_ready = grant;
                    req_d         = bus.req_in[grant_idx];
                    owner_d       = grant_idx;
                    state_d       = TPA_ISSUE;
                end
            end
            TPA_ISSUE: begin
                bus.dp_i_valid = 1'b1;
                if (bus.dp_i_ready) begin
                    state_d = TPA_WAIT;
                end
            end
            TPA_WAIT: begin
                bus.dp_o_ready = 1'b1;
                if (bus.dp_o_valid) begin
                    rsp_d   = bus.dp_o_out;
                    state_d = TPA_RETURN;
                end
            end
            TPA_RETURN: begin
                bus.rsp_valid[owner_q] = 1'b1;
                if (bus.rsp_ready[owner_q]) begin
                    rr_ptr_d = OWNER_W'(rr_next(32'(owner_q), N_REQ));
                    state_d  = TPA_IDLE;
                end
            end
            default: state_d = TPA_IDLE;
        endcase

        if (bus.dp_o_valid && (state_q != TPA_WAIT)) begin
            err_d = 1'b1;
        end
    end

    assign bus.dp_i_in = req_q;
    assign bus.rsp_out = rsp_q;
    assign busy        = (state_q != TPA_IDLE);
    assign owner       = owner_q;
    assign err_stray   = err_q;

endmodule

// File: tb/tb_two_power_arbiter.sv
// Directed plus randomized bench for two_power_arbiter with a round-robin reference
// model and a behavioural 2^power mod modulus datapath.
module tb_two_power_arbiter;
    import two_power_arbiter_pkg::*;

    localparam int N = 4;
    typedef logic [1:0] port_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic [1:0] owner;
    logic       err_stray;

    always #5 clk = ~clk;

    two_power_arbiter_if #(.N_REQ(N)) bus();

    two_power_arbiter #(
        .N_REQ(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .owner    (owner),
        .err_stray(err_stray)
    );

    int         total = 0;
    int         bad = 0;
    int         rr_m = 0;
    TwoPowerIn  jobs [N];
    logic [15:0] last_rsp = '0;
    port_t      g;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] two_pow(input logic [15:0] pw, input logic [15:0] md);
        longint unsigned r;
        r = 64'd1 % 64'(md);
        for (int k = 0; k < int'(pw); k++) r = (r * 2) % 64'(md);
        return 16'(r);
    endfunction

    task automatic post(input port_t p, input int unsigned pw, input int unsigned md);
        jobs[p].power      = 16'(pw);
        jobs[p].modulus    = 16'(md);
        bus.req_in[p]      = jobs[p];
        bus.req_valid[p]   = 1'b1;
    endtask

    // Reference: first valid requester at or after the round-robin pointer.
    task automatic serve(input int rsp_stall, output port_t gr);
        logic        found;
        logic [3:0]  onehot;
        logic [15:0] res;
        #1;
        found = 1'b0;
        gr    = '0;
        for (int k = 0; k < N; k++) begin
            port_t i;
            i = 2'((rr_m + k) % N);
            if (!found && bus.req_valid[i]) begin
                found = 1'b1;
                gr    = i;
            end
        end
        onehot = 4'd1 << gr;
        res    = two_pow(jobs[gr].power, jobs[gr].modulus);
        chk("req_ready", 64'(bus.req_ready), 64'(onehot));
        chk("idle_busy", 64'(busy), 64'(0));
        cyc();
        bus.req_valid[gr] = 1'b0;
        chk("owner", 64'(owner), 64'(gr));
        chk("dp_i_valid", 64'(bus.dp_i_valid), 64'(1));
        chk("dp_i_in", 64'(bus.dp_i_in), 64'(jobs[gr]));
        chk("issue_req_ready", 64'(bus.req_ready), 64'(0));
        repeat ($urandom_range(0, 3)) cyc();
        chk("dp_i_hold", 64'(bus.dp_i_valid), 64'(1));
        bus.dp_i_ready = 1'b1;
        cyc();
        bus.dp_i_ready = 1'b0;
        chk("wait_dp_i_valid", 64'(bus.dp_i_valid), 64'(0));
        chk("dp_o_ready", 64'(bus.dp_o_ready), 64'(1));
        repeat ($urandom_range(0, 3)) cyc();
        bus.dp_o_valid = 1'b1;
        bus.dp_o_out   = TwoPowerOut'(res);
        cyc();
        bus.dp_o_valid = 1'b0;
        bus.dp_o_out   = TwoPowerOut'(16'($urandom));
        chk("ret_dp_o_ready", 64'(bus.dp_o_ready), 64'(0));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(onehot));
        chk("rsp_out", 64'(bus.rsp_out), 64'(res));
        // Other ports' rsp_ready must be ignored.
        bus.rsp_ready = 4'($urandom) & ~onehot;
        repeat (rsp_stall) cyc();
        chk("rsp_valid_hold", 64'(bus.rsp_valid), 64'(onehot));
        chk("rsp_out_hold", 64'(bus.rsp_out), 64'(res));
        chk("ret_req_ready", 64'(bus.req_ready), 64'(0));
        bus.rsp_ready = onehot;
        cyc();
        bus.rsp_ready = '0;
        rr_m     = (int'(gr) + 1) % N;
        last_rsp = res;
        chk("done_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("done_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_in     = '0;
        bus.rsp_ready  = '0;
        bus.dp_i_ready = 1'b0;
        bus.dp_o_valid = 1'b0;
        bus.dp_o_out   = '0;

        // Reset state with requests already pending.
        bus.req_valid = 4'hf;
        #12;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("rst_dp_i_valid", 64'(bus.dp_i_valid), 64'(0));
        chk("rst_dp_o_ready", 64'(bus.dp_o_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_owner", 64'(owner), 64'(0));
        chk("rst_err", 64'(err_stray), 64'(0));
        chk("rst_rsp_out", 64'(bus.rsp_out), 64'(0));
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // All four at once, then req0 again: expected order 0,1,2,3,0.
        post(2'd0, 3, 11);
        post(2'd1, 7, 19);
        post(2'd2, 12, 23);
        post(2'd3, 9, 29);
        serve(0, g);
        post(2'd0, 20, 101);
        repeat (4) serve(1, g);

        // Single job {5,13} -> 6.
        post(2'd0, 5, 13);
        serve(0, g);
        post(2'd1, 2, 5);
        serve(0, g);

        // req2 {10,7} -> 2 held 20 cycles while req3 waits; req3 {0,97} -> 1.
        post(2'd2, 10, 7);
        post(2'd3, 0, 97);
        serve(20, g);
        serve(0, g);

        // Pointer wrapped to 0: req0 wins over req1.
        post(2'd1, 33, 1000);
        post(2'd0, 8, 300);
        serve(0, g);
        serve(0, g);

        // Randomized traffic; requests stay valid until granted.
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < N; p++) begin
                if (!bus.req_valid[p] && $urandom_range(0, 1) == 1) begin
                    post(2'(p), $urandom_range(0, 40), $urandom_range(2, 65535));
                end
            end
            if (bus.req_valid == '0) begin
                post(2'($urandom_range(0, 3)), $urandom_range(0, 40), $urandom_range(2, 65535));
            end
            serve($urandom_range(0, 2), g);
        end
        bus.req_valid = '0;
        cyc();

        // Stray datapath result in IDLE.
        bus.dp_o_valid = 1'b1;
        bus.dp_o_out   = TwoPowerOut'(16'h5a5a);
        #1;
        chk("stray_dp_o_ready", 64'(bus.dp_o_ready), 64'(0));
        cyc();
        bus.dp_o_valid = 1'b0;
        chk("stray_err", 64'(err_stray), 64'(1));
        chk("stray_no_capture", 64'(bus.rsp_out), 64'(last_rsp));
        chk("stray_idle", 64'(busy), 64'(0));
        repeat (3) cyc();
        chk("stray_sticky", 64'(err_stray), 64'(1));
        post(2'd1, 13, 1000);
        serve(0, g);
        chk("stray_sticky_after_job", 64'(err_stray), 64'(1));

        // Reset while waiting on the datapath.
        post(2'd1, 17, 257);
        #1;
        cyc();
        bus.req_valid[1] = 1'b0;
        bus.dp_i_ready   = 1'b1;
        cyc();
        bus.dp_i_ready = 1'b0;
        chk("pre_rst_wait", 64'(bus.dp_o_ready), 64'(1));
        post(2'd2, 4, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("mid_rst_dp_o_ready", 64'(bus.dp_o_ready), 64'(0));
        chk("mid_rst_dp_i_valid", 64'(bus.dp_i_valid), 64'(0));
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_owner", 64'(owner), 64'(0));
        chk("mid_rst_err", 64'(err_stray), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        rr_m  = 0;
        post(2'd0, 6, 50);
        serve(0, g);
        serve(0, g);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
